// File: rtl/render_div_pkg.sv
// render_div_pkg: shared divider constants and tag-width helper
package render_div_pkg;
  localparam int DIV_W = 21;
  localparam int DIV21_LAT = 25;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/div21_tag_fifo.sv
// div21_tag_fifo: synchronous FIFO with async active-low reset, full/empty flags
module div21_tag_fifo
  import render_div_pkg::*;
#(
  parameter int W = 2,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt;
  logic wr, rd;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  assign rd = pop && !empty;
  // a push into a full FIFO is fine when the same cycle pops the head slot
  assign wr = push && (!full || rd);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/div21_share_sched.sv
// div21_share_sched: round-robin sharing of one pipelined 21-bit divider; DIV21_SCHED_PERF_EN adds perf counters
module div21_share_sched
  import render_div_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = DIV21_LAT,
  parameter int TAG_DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*DIV_W-1:0] req_dividend,
  input  logic [NUM_REQ*DIV_W-1:0] req_divisor,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     div_open,
  output logic [DIV_W-1:0]         div_dividend,
  output logic [DIV_W-1:0]         div_divisor,
  input  logic                     div_finish,
  input  logic [DIV_W-1:0]         div_quotient,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DIV_W-1:0]         rsp_quotient,
  output logic                     busy,
  output logic                     err_orphan
`ifdef DIV21_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_issue,
  output logic [31:0]              perf_stall
`endif
);
  localparam int TW = clog2(NUM_REQ);
  localparam int IW = clog2(TAG_DEPTH) + 1;
  localparam int FW = clog2(DIV_LAT + 2);
  logic [FW-1:0] flush_cnt;
  logic [TW-1:0] rr_ptr, gidx, issue_tag, tag_out;
  logic [TW:0] idx;
  logic [IW-1:0] inflight;
  logic found, live, can_grant, tag_full, tag_empty, pop;
  assign live = flush_cnt == '0;
  // the registered issue stage holds one op not yet counted in inflight
  assign can_grant = live && !tag_full && (inflight + IW'(div_open)) < IW'(TAG_DEPTH);
  assign pop = div_finish && !tag_empty && live;
  assign busy = !live || inflight != '0 || div_open;
  always_comb begin
    found = 1'b0;
    gidx = '0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (TW+1)'(k);
      idx = idx >= (TW+1)'(NUM_REQ) ? idx - (TW+1)'(NUM_REQ) : idx;
      if (!found && req[idx[TW-1:0]]) begin
        found = 1'b1;
        gidx = idx[TW-1:0];
      end
    end
    gnt = (found && can_grant) ? NUM_REQ'(1) << gidx : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= FW'(DIV_LAT + 1);
      rr_ptr <= '0;
      issue_tag <= '0;
      div_open <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      rsp_valid <= '0;
      rsp_quotient <= '0;
      inflight <= '0;
      err_orphan <= 1'b0;
    end else begin
      flush_cnt <= live ? flush_cnt : flush_cnt - 1'b1;
      div_open <= |gnt;
      if (|gnt) begin
        rr_ptr <= gidx == TW'(NUM_REQ - 1) ? '0 : gidx + 1'b1;
        issue_tag <= gidx;
        div_dividend <= req_dividend[DIV_W*gidx +: DIV_W];
        div_divisor <= req_divisor[DIV_W*gidx +: DIV_W];
      end
      rsp_valid <= pop ? NUM_REQ'(1) << tag_out : '0;
      if (pop) rsp_quotient <= div_quotient;
      inflight <= inflight + IW'(div_open) - IW'(pop);
      err_orphan <= err_orphan | (div_finish && tag_empty && live);
    end
  end
  div21_tag_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(div_open),
    .din(issue_tag),
    .pop(pop),
    .dout(tag_out),
    .full(tag_full),
    .empty(tag_empty)
  );
`ifdef DIV21_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      perf_issue <= (div_open && !(&perf_issue)) ? perf_issue + 1'b1 : perf_issue;
      perf_stall <= (live && |req && gnt == '0 && !(&perf_stall)) ? perf_stall + 1'b1 : perf_stall;
    end
  end
`endif
endmodule
